ldr_writeback_queue: RTL

- Parametrised load-writeback stage for the pipelined ARM32 core. It sits between the memory stage and the register-file write port.
- Tracks up to DEPTH outstanding loads in issue order, pairs each variable-latency memory response with its destination register, and extracts and zero-extends byte/halfword data.
- Issues a registered register-file write.
- Squashes in-flight loads on a branch without losing response alignment. Stalls the pipeline when the tracking queue is full.

---
 rtl/ldr_writeback_queue_if.sv | 36 +++
 rtl/ldr_writeback_queue.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ldr_writeback_queue_if.sv
// Bus between the memory stage / register file and the load writeback queue.
interface ldr_writeback_queue_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int REG_W  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              iss_valid;
  logic [6:0]        iss_opcode;
  logic [REG_W-1:0]  iss_rd;
  logic [1:0]        iss_size;
  logic [1:0]        iss_offs;
  logic              sel_stall;
  logic              branch_in;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ready;
  logic              stall_out;
  logic [CNT_W-1:0]  outstanding;
  logic              w_en_ldr;
  logic [REG_W-1:0]  w_addr_ldr;
  logic [DATA_W-1:0] w_data_ldr;

  modport slave (
    input  iss_valid, iss_opcode, iss_rd, iss_size, iss_offs, sel_stall, branch_in,
    input  rsp_valid, rsp_data,
    output rsp_ready, stall_out, outstanding, w_en_ldr, w_addr_ldr, w_data_ldr
  );

  modport master (
    output iss_valid, iss_opcode, iss_rd, iss_size, iss_offs, sel_stall, branch_in,
    output rsp_valid, rsp_data,
    input  rsp_ready, stall_out, outstanding, w_en_ldr, w_addr_ldr, w_data_ldr
  );
endinterface

// File: rtl/ldr_writeback_queue.sv
// Load writeback queue: tracks outstanding loads in issue order, pairs each
// memory response with its destination register, zero-extends sub-word data
// and issues a registered register-file write. Branches squash held entries
// but keep them queued so late responses stay aligned.
module ldr_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int REG_W  = 4
) (
  input  logic clk,
  input  logic rst_n,   // active-high asynchronous reset
  ldr_writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [DEPTH-1:0][REG_W-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][1:0]       size_q, size_d;
  logic [DEPTH-1:0][1:0]       offs_q, offs_d;
  logic [DEPTH-1:0]            live_q, live_d;
  logic                        w_en_q, w_en_d;
  logic [REG_W-1:0]            w_addr_q, w_addr_d;
  logic [DATA_W-1:0]           w_data_q, w_data_d;

  logic              is_load, full, empty, push, pop;
  logic [1:0]        hd_size, hd_offs;
  logic [DATA_W-1:0] ext_data;

  // Issue/response qualification; a full queue blocks push even when popping.
  always_comb begin
    is_load = (bus.iss_opcode[6:4] == 3'b110) || (bus.iss_opcode[6:3] == 4'b1000);
    full    = (count_q == FULL);
    empty   = (count_q == '0);
    push    = bus.iss_valid & is_load & ~bus.sel_stall & ~bus.branch_in & ~full;
    pop     = bus.rsp_valid & ~empty;
  end

  // Extract and zero-extend the response according to the head entry.
  always_comb begin
    hd_size  = size_q[head_q];
    hd_offs  = offs_q[head_q];
    ext_data = '0;
    case (hd_size)
      2'b01:   ext_data[15:0] = bus.rsp_data[{hd_offs[1], 4'b0000} +: 16];
      2'b10:   ext_data[7:0]  = bus.rsp_data[{hd_offs, 3'b000} +: 8];
      default: ext_data       = bus.rsp_data;
    endcase
  end

  // Next-state for queue pointers, entries and the writeback register.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    rd_d     = rd_q;
    size_d   = size_q;
    offs_d   = offs_q;
    live_d   = live_q;
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;

    if (pop) begin
      // A branch in the same cycle kills the popped entry's write too.
      if (live_q[head_q] && !bus.branch_in) begin
        w_en_d   = 1'b1;
        w_addr_d = rd_q[head_q];
        w_data_d = ext_data;
      end
      live_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end

    if (bus.branch_in) live_d = '0;

    // push already excludes branch cycles, so the new entry is always live.
    if (push) begin
      rd_d[tail_q]   = bus.iss_rd;
      size_d[tail_q] = bus.iss_size;
      offs_d[tail_q] = bus.iss_offs;
      live_d[tail_q] = 1'b1;
      tail_d         = tail_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rd_q     <= '0;
      size_q   <= '0;
      offs_q   <= '0;
      live_q   <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      size_q   <= size_d;
      offs_q   <= offs_d;
      live_q   <= live_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign bus.rsp_ready   = ~empty;
  assign bus.stall_out   = bus.iss_valid & is_load & full;
  assign bus.outstanding = count_q;
  assign bus.w_en_ldr    = w_en_q;
  assign bus.w_addr_ldr  = w_addr_q;
  assign bus.w_data_ldr  = w_data_q;
endmodule
